wb_writer: RTL

- Write-side driver for the 32x32 register file write port (we/waddr/wdata).
- Merges two writeback sources into a single registered write stream:
  - primary: the single-cycle ALU/load path.
  - secondary: long-latency units (mult/div, HI/LO moves), buffered in a small FIFO.
- Suppresses writes to $0.
- Flags read hazards for operands whose write is still pending.

---
 rtl/mips_pkg.sv | 13 +
 rtl/wb_fifo.sv | 90 +++++++++
 rtl/wb_writer.sv | 119 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared register-file writeback constants and the request record carried through the write path.
package mips_pkg;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular queue for long-latency writebacks, exposing every entry's address for hazard lookup.
// Latency: a pushed entry is visible at the head on the following cycle.
// Backpressure: full/empty come from registered count; caller never pushes when full nor pops when empty.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [AW-1:0]               push_addr,
  input  logic [DW-1:0]               push_data,
  input  logic                        pop,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic [AW-1:0]               head_addr,
  output logic [DW-1:0]               head_data,
  output logic [DEPTH-1:0]            ent_vld,
  output logic [DEPTH-1:0][AW-1:0]    ent_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (push) begin
      addr_d[wr_ptr_q] = push_addr;
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: validity is defined purely by pointers and count.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  // Entry i is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    ent_vld  = '0;
    ent_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_vld[i]  = ({1'b0, PW'(i) - rd_ptr_q} < cnt_q);
      ent_addr[i] = addr_q[i];
    end
  end

  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;
  assign head_addr = addr_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];

endmodule

// File: rtl/wb_writer.sv
// Merges primary and queued secondary writebacks into one registered RF write port; WB_BYPASS_EN lets idle secondaries skip the queue.
// Latency: primary 1 cycle; secondary 2 cycles via the queue (1 cycle when bypassed).
// Backpressure: primary always accepted; s_ready drops only when the queue is full (registered, no path from p_valid).
module wb_writer #(
  parameter int DEPTH = 4,
  parameter int AW    = mips_pkg::AW,
  parameter int DW    = mips_pkg::DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   p_valid,
  input  logic [AW-1:0]          p_addr,
  input  logic [DW-1:0]          p_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [AW-1:0]          s_addr,
  input  logic [DW-1:0]          s_data,
  input  logic [AW-1:0]          raddr1,
  input  logic [AW-1:0]          raddr2,
  output logic                   hazard1,
  output logic                   hazard2,
  output logic                   we,
  output logic [AW-1:0]          waddr,
  output logic [DW-1:0]          wdata,
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  import mips_pkg::*;

  wb_req_t out_q, out_d;
  logic    we_q, we_d;

  logic                     p_hit;
  logic                     s_take;
  logic                     s_fwd;
  logic                     f_push;
  logic                     f_pop;
  logic                     f_full;
  logic                     f_empty;
  logic [AW-1:0]            f_head_addr;
  logic [DW-1:0]            f_head_data;
  logic [DEPTH-1:0]         f_ent_vld;
  logic [DEPTH-1:0][AW-1:0] f_ent_addr;

  wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (f_push),
    .push_addr (s_addr),
    .push_data (s_data),
    .pop       (f_pop),
    .full      (f_full),
    .empty     (f_empty),
    .count     (fifo_cnt),
    .head_addr (f_head_addr),
    .head_data (f_head_data),
    .ent_vld   (f_ent_vld),
    .ent_addr  (f_ent_addr)
  );

  assign s_ready = !f_full;
  assign p_hit   = p_valid && (p_addr != REG_ZERO);
  // $0 secondaries are handshaken normally but dropped here.
  assign s_take  = s_valid && s_ready && (s_addr != REG_ZERO);

`ifdef WB_BYPASS_EN
  assign s_fwd = s_take && f_empty && !p_hit;
`else
  assign s_fwd = 1'b0;
`endif

  assign f_push = s_take && !s_fwd;
  assign f_pop  = !p_hit && !f_empty;

  always_comb begin
    we_d  = 1'b1;
    out_d = out_q;
    if (p_hit) begin
      out_d = '{addr: p_addr, data: p_data};
    end else if (f_pop) begin
      out_d = '{addr: f_head_addr, data: f_head_data};
    end else if (s_fwd) begin
      out_d = '{addr: s_addr, data: s_data};
    end else begin
      we_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q  <= 1'b0;
      out_q <= '0;
    end else begin
      we_q  <= we_d;
      out_q <= out_d;
    end
  end

  assign we    = we_q;
  assign waddr = out_q.addr;
  assign wdata = out_q.data;

  // Pending writes are the in-flight output stage plus every live queue entry.
  always_comb begin
    hazard1 = we_q && (out_q.addr == raddr1);
    hazard2 = we_q && (out_q.addr == raddr2);
    for (int i = 0; i < DEPTH; i++) begin
      if (f_ent_vld[i] && (f_ent_addr[i] == raddr1)) hazard1 = 1'b1;
      if (f_ent_vld[i] && (f_ent_addr[i] == raddr2)) hazard2 = 1'b1;
    end
    if (raddr1 == REG_ZERO) hazard1 = 1'b0;
    if (raddr2 == REG_ZERO) hazard2 = 1'b0;
  end

endmodule
